// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Definitions shared by the PC register and the instruction fetch stage, so
// that both agree on the vectors and on the fetch state encoding.
//   fetch_state_e : fetch FSM states (IDLE, REQ, DRAIN)
//   NOP           : all-zero instruction word (sll $0,$0,0)
//   RESET_VECTOR  : boot address after reset
//   EXC_VECTOR    : general exception vector
//   INT_VECTOR    : interrupt vector (Cause.IV set)
//   is_word_aligned() : true when an address is a legal instruction address
// ---------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP          = 32'h0000_0000;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VECTOR   = 32'h8000_0180;
    localparam logic [31:0] INT_VECTOR   = 32'h8000_0200;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// ---------------------------------------------------------------------------
// ifetch_unit_if
// Instruction memory bus between the fetch stage and instruction memory.
//   mem_addr  : word address driven by the fetch stage
//   mem_req   : request, held until mem_ack is seen
//   mem_ack   : acknowledge; mem_rdata is valid in the same cycle
//   mem_rdata : instruction word returned by memory
// Modports: master (fetch stage), slave (memory).
// ---------------------------------------------------------------------------
interface ifetch_unit_if;

    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_req,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_req,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/ifetch_timeout.sv
// ---------------------------------------------------------------------------
// ifetch_timeout
// Wait-cycle counter for the fetch stage; only built when IFETCH_TIMEOUT_EN
// is defined.
//   clk, reset : clock, asynchronous active-high reset
//   clear_i    : restart the count (entry into REQ or DRAIN)
//   count_i    : a bus wait cycle (request outstanding, no ack)
//   expired_o  : this wait cycle is the TIMEOUT_CYCLES-th one in a row
// ---------------------------------------------------------------------------
module ifetch_timeout #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_W      = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);

    localparam logic [TIMEOUT_W-1:0] LAST_WAIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] cnt_q;
    logic [TIMEOUT_W-1:0] cnt_d;

    // Next count: clear on state entry has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {TIMEOUT_W{1'b0}};
        end else if (count_i) begin
            cnt_d = cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {TIMEOUT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count holds the number of wait cycles already completed, so the
    // current wait cycle is the last allowed one when it equals LAST_WAIT.
    assign expired_o = count_i && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
// Instruction fetch stage: fetches the word at pc_in over the instruction
// bus, latches it into the instruction register, produces PC+4 and reports
// misaligned-address (AdEL) and bus-error (IBE) fetch exceptions.
//   clk, reset  : clock, asynchronous active-high reset
//   pc_in       : current PC
//   fetch_start : one-cycle request to fetch pc_in (ignored while busy)
//   flush       : abandon the fetch in progress
//   mem         : instruction bus (master side)
//   ir_out      : latched instruction
//   pc4_out     : fetched address + 4
//   fetch_done  : pulse, ir_out/pc4_out just updated
//   adel_exc    : pulse, misaligned fetch address
//   ibe_exc     : pulse, bus timeout (only with IFETCH_TIMEOUT_EN)
//   epc_cand    : faulting address, valid with adel_exc/ibe_exc
//   busy        : fetch outstanding (REQ or DRAIN)
// Build option: IFETCH_TIMEOUT_EN adds a bus timeout; without it the unit
// waits for mem_ack indefinitely and ibe_exc stays 0.
// ---------------------------------------------------------------------------
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_IR       = NOP,
    parameter logic [31:0] RESET_PC4      = RESET_VECTOR + 32'd4,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter int          TIMEOUT_W      = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         pc_in,
    input  logic                fetch_start,
    input  logic                flush,
    ifetch_unit_if.master       mem,
    output logic [31:0]         ir_out,
    output logic [31:0]         pc4_out,
    output logic                fetch_done,
    output logic                adel_exc,
    output logic                ibe_exc,
    output logic [31:0]         epc_cand,
    output logic                busy
);

    fetch_state_e state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic         req_q, req_d;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  pc4_q, pc4_d;
    logic [31:0]  epc_q, epc_d;
    logic         done_q, done_d;
    logic         adel_q, adel_d;
    logic         ibe_q, ibe_d;
    logic         busy_q, busy_d;
    logic         timeout_s;

`ifdef IFETCH_TIMEOUT_EN
    logic tmo_clear_s;
    logic tmo_count_s;

    // Restart on every entry into a waiting state; count waits without ack.
    assign tmo_clear_s = (state_d != state_q) && (state_d != IDLE);
    assign tmo_count_s = (state_q != IDLE) && !mem.mem_ack;

    ifetch_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (tmo_clear_s),
        .count_i   (tmo_count_s),
        .expired_o (timeout_s)
    );
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output logic of the fetch FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        req_d   = req_q;
        ir_d    = ir_q;
        pc4_d   = pc4_q;
        epc_d   = epc_q;
        done_d  = 1'b0;
        adel_d  = 1'b0;
        ibe_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Flush beats a simultaneous fetch_start.
                if (flush) begin
                    state_d = IDLE;
                end else if (fetch_start) begin
                    addr_d = pc_in;
                    if (!is_word_aligned(pc_in)) begin
                        adel_d = 1'b1;
                        epc_d  = pc_in;
                    end else begin
                        req_d   = 1'b1;
                        state_d = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            REQ: begin
                if (mem.mem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (!flush) begin
                        ir_d   = mem.mem_rdata;
                        pc4_d  = addr_q + 32'd4;
                        done_d = 1'b1;
                    end else begin
                        done_d = 1'b0;
                    end
                end else if (timeout_s) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    if (!flush) begin
                        ibe_d = 1'b1;
                        epc_d = addr_q;
                    end else begin
                        ibe_d = 1'b0;
                    end
                end else if (flush) begin
                    // The request cannot be withdrawn; wait for its ack.
                    state_d = DRAIN;
                end else begin
                    state_d = REQ;
                end
            end

            DRAIN: begin
                if (mem.mem_ack || timeout_s) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end

            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 32'h0000_0000;
            req_q   <= 1'b0;
            ir_q    <= RESET_IR;
            pc4_q   <= RESET_PC4;
            epc_q   <= 32'h0000_0000;
            done_q  <= 1'b0;
            adel_q  <= 1'b0;
            ibe_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            ir_q    <= ir_d;
            pc4_q   <= pc4_d;
            epc_q   <= epc_d;
            done_q  <= done_d;
            adel_q  <= adel_d;
            ibe_q   <= ibe_d;
            busy_q  <= busy_d;
        end
    end

    assign mem.mem_addr = addr_q;
    assign mem.mem_req  = req_q;
    assign ir_out       = ir_q;
    assign pc4_out      = pc4_q;
    assign epc_cand     = epc_q;
    assign fetch_done   = done_q;
    assign adel_exc     = adel_q;
    assign ibe_exc      = ibe_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
// Directed and randomized fetch transactions. Inputs change and outputs are
// checked on the falling clock edge. The expected instruction register and
// PC+4 are tracked per transaction from the fetch rules (a fetch updates
// them only when acked without any flush along the way).
// ---------------------------------------------------------------------------
module tb_ifetch_unit;

    localparam logic [31:0] RESET_IR  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC4 = 32'hBFC0_0004;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        fetch_start;
    logic        flush;
    logic [31:0] ir_out;
    logic [31:0] pc4_out;
    logic        fetch_done;
    logic        adel_exc;
    logic        ibe_exc;
    logic [31:0] epc_cand;
    logic        busy;

    ifetch_unit_if bus ();

    ifetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .fetch_start (fetch_start),
        .flush       (flush),
        .mem         (bus),
        .ir_out      (ir_out),
        .pc4_out     (pc4_out),
        .fetch_done  (fetch_done),
        .adel_exc    (adel_exc),
        .ibe_exc     (ibe_exc),
        .epc_cand    (epc_cand),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_ir;
    logic [31:0] exp_pc4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One fetch starting at the current falling edge. delay = wait cycles
    // before ack, flush_at = wait-cycle index carrying flush (-1: none).
    task automatic fetch(input logic [31:0] a, input int delay, input int flush_at,
                         input logic [31:0] rdata);
        logic flushed;
        logic [1:0] low;
        flushed     = 1'b0;
        low         = a[1:0];
        pc_in       = a;
        fetch_start = 1'b1;
        flush       = 1'b0;
        @(negedge clk);
        fetch_start = 1'b0;
        pc_in       = $urandom;
        if (low != 2'b00) begin
            check("adel_pulse", {31'd0, adel_exc}, 32'd1);
            check("adel_epc", epc_cand, a);
            check("adel_noreq", {31'd0, bus.mem_req}, 32'd0);
            check("adel_busy", {31'd0, busy}, 32'd0);
            check("adel_ir", ir_out, exp_ir);
            @(negedge clk);
            check("adel_once", {31'd0, adel_exc}, 32'd0);
            return;
        end
        for (int i = 0; i <= delay; i++) begin
            check("wait_req", {31'd0, bus.mem_req}, 32'd1);
            check("wait_addr", bus.mem_addr, a);
            check("wait_busy", {31'd0, busy}, 32'd1);
            check("wait_nodone", {31'd0, fetch_done}, 32'd0);
            bus.mem_ack   = (i == delay);
            bus.mem_rdata = (i == delay) ? rdata : 32'($urandom);
            flush         = (i == flush_at);
            if (i == flush_at) flushed = 1'b1;
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        flush       = 1'b0;
        if (!flushed) begin
            exp_ir  = rdata;
            exp_pc4 = a + 32'd4;
        end
        check("end_req", {31'd0, bus.mem_req}, 32'd0);
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_done", {31'd0, fetch_done}, {31'd0, !flushed});
        check("end_ir", ir_out, exp_ir);
        check("end_pc4", pc4_out, exp_pc4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          dly;
        int          fa;
        reset         = 1'b1;
        pc_in         = 32'h0000_0000;
        fetch_start   = 1'b0;
        flush         = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0000_0000;
        exp_ir        = RESET_IR;
        exp_pc4       = RESET_PC4;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'h0000_0000);
        check("rst_ir", ir_out, RESET_IR);
        check("rst_pc4", pc4_out, RESET_PC4);
        check("rst_epc", epc_cand, 32'h0000_0000);
        check("rst_flags", {28'd0, fetch_done, adel_exc, ibe_exc, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Boot fetch with immediate ack
        fetch(32'hBFC0_0000, 0, -1, 32'h3C1D_8000);
        @(negedge clk);
        check("boot_done_once", {31'd0, fetch_done}, 32'd0);

        // Misaligned fetch
        fetch(32'h8000_0182, 0, -1, 32'h0);

        // Flush in second wait cycle, ack after 3 waits
        fetch(32'h0040_0000, 3, 1, 32'h1234_5678);

        // Flush and ack in the same cycle
        fetch(32'h0040_0004, 2, 2, 32'hDEAD_BEEF);

        // Address wrap of PC+4
        fetch(32'hFFFF_FFFC, 1, -1, 32'hAAAA_5555);

        // Back-to-back fetches (second starts in the done cycle)
        fetch(32'h0040_0100, 0, -1, 32'h0000_1111);
        fetch(32'h0040_0104, 0, -1, 32'h0000_2222);

        // Flush together with fetch_start in IDLE: ignored
        pc_in       = 32'h0040_0200;
        fetch_start = 1'b1;
        flush       = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        flush       = 1'b0;
        check("idleflush_req", {31'd0, bus.mem_req}, 32'd0);
        check("idleflush_busy", {31'd0, busy}, 32'd0);
        pc_in       = 32'h0040_0203;
        fetch_start = 1'b1;
        flush       = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        flush       = 1'b0;
        check("idleflush_noadel", {31'd0, adel_exc}, 32'd0);

        // fetch_start while busy is ignored
        pc_in       = 32'h0040_0300;
        fetch_start = 1'b1;
        @(negedge clk);
        pc_in       = 32'h0040_0400;
        @(negedge clk);
        fetch_start = 1'b0;
        check("busy_ignore_addr", bus.mem_addr, 32'h0040_0300);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        exp_ir  = 32'h0BAD_F00D;
        exp_pc4 = 32'h0040_0304;
        check("busy_ignore_pc4", pc4_out, exp_pc4);
        check("busy_ignore_ir", ir_out, exp_ir);
        @(negedge clk);
        check("busy_ignore_idle", {31'd0, bus.mem_req}, 32'd0);

        // Reset while REQ is waiting
        pc_in       = 32'h0040_0010;
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        check("rstmid_req_before", {31'd0, bus.mem_req}, 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        exp_ir  = RESET_IR;
        exp_pc4 = RESET_PC4;
        check("rstmid_req", {31'd0, bus.mem_req}, 32'd0);
        check("rstmid_ir", ir_out, exp_ir);
        check("rstmid_pc4", pc4_out, exp_pc4);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("rstmid_lateack_done", {31'd0, fetch_done}, 32'd0);
        check("rstmid_lateack_ir", ir_out, exp_ir);
        check("rstmid_lateack_busy", {31'd0, busy}, 32'd0);

`ifdef IFETCH_TIMEOUT_EN
        // Never acked: bus error after 16 wait cycles
        pc_in       = 32'h0040_0020;
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            check("tmo_req_held", {31'd0, bus.mem_req}, 32'd1);
            check("tmo_no_ibe", {31'd0, ibe_exc}, 32'd0);
            @(negedge clk);
        end
        check("tmo_req", {31'd0, bus.mem_req}, 32'd0);
        check("tmo_ibe", {31'd0, ibe_exc}, 32'd1);
        check("tmo_epc", epc_cand, 32'h0040_0020);
        check("tmo_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("tmo_ibe_once", {31'd0, ibe_exc}, 32'd0);
`else
        // Long wait without timeout support: request held, no bus error
        fetch(32'h0040_0020, 20, -1, 32'h0F0F_0F0F);
        check("notmo_ibe", {31'd0, ibe_exc}, 32'd0);
`endif

        // Randomized transactions (waits stay below the timeout)
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if ($urandom_range(0, 99) >= 15) a[1:0] = 2'b00;
            else if (a[1:0] == 2'b00) a[0] = 1'b1;
            dly = $urandom_range(0, 4);
            fa  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, dly) : -1;
            fetch(a, dly, fa, 32'($urandom));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage directly downstream of the PC register. It takes the current PC value, runs a request/acknowledge transaction on the instruction memory bus, and latches the returned word into the instruction register. It also produces PC+4 for the sequential-PC path and reports fetch exceptions, with the faulting address, to the exception/CP0 logic.

Parameters:
RESET_IR, 32'h00000000, instruction register value at reset (NOP)
RESET_PC4, 32'hBFC00004, pc4_out value at reset (boot vector + 4)
TIMEOUT_CYCLES, 16, cycles spent waiting for mem_ack before a bus error; used only with IFETCH_TIMEOUT_EN
TIMEOUT_W, 5, width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising-edge
reset  in  1  reset, asynchronous, active-high
pc_in  in  32  current PC from the PC register
fetch_start  in  1  single-cycle pulse from control: begin a fetch of pc_in
flush  in  1  abandon the fetch in progress (redirect or exception)
mem_addr  out  32  instruction bus address
mem_req  out  1  instruction bus request
mem_ack  in  1  bus acknowledge; mem_rdata is valid in the same cycle
mem_rdata  in  32  instruction word from memory
ir_out  out  32  latched instruction
pc4_out  out  32  fetched address + 4
fetch_done  out  1  one-cycle pulse: ir_out and pc4_out have just been updated
adel_exc  out  1  one-cycle pulse: misaligned fetch address
ibe_exc  out  1  one-cycle pulse: instruction bus error (timeout)
epc_cand  out  32  address of the faulting fetch; valid while adel_exc or ibe_exc is high
busy  out  1  high in REQ or DRAIN

Behaviour:
- Reset values: state=IDLE, mem_req=0, mem_addr=0, ir_out=RESET_IR, pc4_out=RESET_PC4, epc_cand=0, and fetch_done, adel_exc, ibe_exc, busy all 0.
- Reset is asynchronous. Asserting it mid-transaction drops mem_req immediately, and no response is consumed afterwards.
- All outputs are registered. There are three states: IDLE, REQ and DRAIN.
- IDLE, fetch_start=1 and flush=0:
  - Latch pc_in into the address register.
  - If pc_in[1:0] != 0: no bus request; adel_exc=1 for the next cycle; epc_cand=pc_in; stay in IDLE.
  - Otherwise: next cycle mem_req=1 and mem_addr=pc_in; go to REQ.
- IDLE, flush=1: fetch_start is ignored. Flush wins when both arrive in the same cycle.
- REQ: mem_req and mem_addr are held stable until mem_ack is sampled high.
  - On ack with flush=0: ir_out=mem_rdata; pc4_out=addr+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000); fetch_done=1 for one cycle; mem_req=0; go to IDLE.
  - On ack with flush=1 in the same cycle: discard the data, no fetch_done, go to IDLE.
  - On flush without ack: go to DRAIN.
- DRAIN: mem_req stays high, because the bus protocol forbids withdrawing a request. On ack, discard the data, drop mem_req, go to IDLE. No done or exception pulse is generated.
- fetch_start during REQ or DRAIN is ignored. Control must wait for busy=0.
- Minimum latency, with mem_ack already high on the first REQ cycle: fetch_start sampled at edge t0, ack sampled at edge t1, fetch_done high in the cycle after t1. A new fetch_start is accepted in that same cycle, so back-to-back fetches are allowed.
- ir_out and pc4_out hold their values except on a completed, non-flushed fetch.

Optional Feature:
IFETCH_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to REQ or DRAIN and increments on each cycle without ack.
  - In REQ, reaching TIMEOUT_CYCLES drops mem_req, pulses ibe_exc with epc_cand=address, and returns to IDLE.
  - In DRAIN, a timeout returns silently to IDLE.
  - A flush arriving in the same cycle as the timeout suppresses ibe_exc.
- Undefined: ibe_exc is tied to 0 and the unit waits for ack indefinitely.

Decomposition:
- Shared package mips_pkg: fetch state encoding (IDLE, REQ, DRAIN), NOP constant, reset/boot vector constants (0xBFC00000), and the exception/interrupt vectors (0x80000180, 0x80000200), so PC and fetch agree on them.
- Optional sub-module ifetch_timeout: counter plus terminal-count compare, instantiated only under IFETCH_TIMEOUT_EN. All other logic stays flat.

Test Plan:
- Reset, then fetch_start with pc_in=0xBFC00000; ack on the first REQ cycle with rdata=0x3C1D8000 -> mem_addr=0xBFC00000, ir_out=0x3C1D8000, pc4_out=0xBFC00004, fetch_done pulses exactly once.
- pc_in=0x80000182, fetch_start -> mem_req never asserts; adel_exc pulses once with epc_cand=0x80000182; ir_out is unchanged.
- Fetch 0x00400000; ack delayed 3 cycles; flush in the second wait cycle -> mem_req held until ack, then 0; no fetch_done; ir_out and pc4_out unchanged.
- pc_in=0xFFFFFFFC fetched and acked -> pc4_out=0x00000000.
- Fetch 0x00400010; assert reset while REQ is waiting -> mem_req=0 immediately, ir_out=RESET_IR; a late ack is ignored.
- With IFETCH_TIMEOUT_EN: fetch 0x00400020 and never ack -> after 16 wait cycles mem_req=0, ibe_exc pulses with epc_cand=0x00400020, busy=0.
